// File: rtl/klotski_pkg.sv
// Shared types for the klotski solver hand-off controller.
// Build option: KLOTSKI_BLANK_CHECK_EN enables the single-blank board check.
package klotski_pkg;

    localparam int unsigned DEF_ROWS   = 4;
    localparam int unsigned DEF_COLS   = 4;
    localparam int unsigned DEF_CELL_W = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE    = 2'd0;
    localparam err_code_t ERR_BOARD   = 2'd1;
    localparam err_code_t ERR_TIMEOUT = 2'd2;
    localparam err_code_t ERR_ABORT   = 2'd3;

    typedef logic [DEF_ROWS-1:0][DEF_COLS-1:0][DEF_CELL_W-1:0] board_t;

endpackage

// File: rtl/klotski_solve_ctrl_board_check.sv
// Combinational board check: valid when exactly one cell is blank (zero).
// Instantiated by klotski_solve_ctrl only when KLOTSKI_BLANK_CHECK_EN is defined.
module klotski_board_check
    import klotski_pkg::*;
#(
    parameter int unsigned ROWS   = DEF_ROWS,
    parameter int unsigned COLS   = DEF_COLS,
    parameter int unsigned CELL_W = DEF_CELL_W
) (
    input  logic [ROWS-1:0][COLS-1:0][CELL_W-1:0] i_board,
    output logic                                  o_valid_c
);

    localparam int unsigned CNT_W = $clog2(ROWS * COLS + 1);

    logic [CNT_W-1:0] w_blank_cnt;

    always_comb begin
        w_blank_cnt = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                if (i_board[r][c] == '0) begin
                    w_blank_cnt = w_blank_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_valid_c = (w_blank_cnt == CNT_W'(1));

endmodule

// File: rtl/klotski_solve_ctrl.sv
// Board hand-off controller: latches a board, checks it, launches and supervises the solver.
// Build option: KLOTSKI_BLANK_CHECK_EN makes CHECK require exactly one blank cell.
module klotski_solve_ctrl
    import klotski_pkg::*;
#(
    parameter int unsigned ROWS      = DEF_ROWS,
    parameter int unsigned COLS      = DEF_COLS,
    parameter int unsigned CELL_W    = DEF_CELL_W,
    parameter int unsigned STEP_W    = 8,
    parameter int unsigned TIMEOUT   = 1000000,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic                                  i_Clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_en,
    input  logic [ROWS-1:0][COLS-1:0][CELL_W-1:0] i_klotski,
    input  logic                                  i_abort,
    input  logic                                  i_alg_done,
    input  logic [STEP_W-1:0]                     i_alg_steps,
    output logic [ROWS-1:0][COLS-1:0][CELL_W-1:0] o_klotski,
    output logic                                  o_start_alg,
    output logic                                  o_busy,
    output logic                                  o_done,
    output logic [STEP_W-1:0]                     o_steps,
    output logic                                  o_err,
    output logic [1:0]                            o_err_code
);

    localparam int unsigned TO_W    = $clog2(TIMEOUT);
    localparam int unsigned RT_RAW  = $clog2(MAX_RETRY + 1);
    localparam int unsigned RT_W    = (RT_RAW < 1) ? 1 : RT_RAW;

    state_t                                r_state;
    logic [TO_W-1:0]                       r_to_cnt;
    logic [RT_W-1:0]                       r_retry;
    logic [ROWS-1:0][COLS-1:0][CELL_W-1:0] r_klotski;
    logic                                  r_start;
    logic                                  r_busy;
    logic                                  r_done;
    logic                                  r_err;
    logic [STEP_W-1:0]                     r_steps;
    err_code_t                             r_err_code;

    state_t                                w_state_nxt;
    logic [TO_W-1:0]                       w_to_cnt_nxt;
    logic [RT_W-1:0]                       w_retry_nxt;
    logic [ROWS-1:0][COLS-1:0][CELL_W-1:0] w_klotski_nxt;
    logic [STEP_W-1:0]                     w_steps_nxt;
    err_code_t                             w_err_code_nxt;
    logic                                  w_board_ok;
    logic                                  w_to_last;
    logic                                  w_retry_ok;

`ifdef KLOTSKI_BLANK_CHECK_EN
    klotski_board_check #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .CELL_W (CELL_W)
    ) u_board_check (
        .i_board   (r_klotski),
        .o_valid_c (w_board_ok)
    );
`else
    assign w_board_ok = 1'b1;
`endif

    assign w_to_last  = (r_to_cnt == TO_W'(TIMEOUT - 1));
    assign w_retry_ok = (r_retry < RT_W'(MAX_RETRY));

    // Next-state logic; abort in an active state overrides every other transition.
    always_comb begin
        w_state_nxt    = r_state;
        w_to_cnt_nxt   = r_to_cnt;
        w_retry_nxt    = r_retry;
        w_klotski_nxt  = r_klotski;
        w_steps_nxt    = r_steps;
        w_err_code_nxt = r_err_code;
        case (r_state)
            S_IDLE: begin
                if (i_en) begin
                    w_state_nxt    = S_CHECK;
                    w_klotski_nxt  = i_klotski;
                    w_steps_nxt    = '0;
                    w_err_code_nxt = ERR_NONE;
                end
            end
            S_CHECK: begin
                if (i_abort) begin
                    w_state_nxt    = S_ERR;
                    w_err_code_nxt = ERR_ABORT;
                end else if (w_board_ok) begin
                    w_state_nxt    = S_START;
                end else begin
                    w_state_nxt    = S_ERR;
                    w_err_code_nxt = ERR_BOARD;
                end
            end
            S_START: begin
                w_to_cnt_nxt = '0;
                if (i_abort) begin
                    w_state_nxt    = S_ERR;
                    w_err_code_nxt = ERR_ABORT;
                end else begin
                    w_state_nxt    = S_WAIT;
                end
            end
            S_WAIT: begin
                w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                if (i_abort) begin
                    w_state_nxt    = S_ERR;
                    w_err_code_nxt = ERR_ABORT;
                end else if (i_alg_done) begin
                    w_state_nxt    = S_DONE;
                    w_steps_nxt    = i_alg_steps;
                end else if (w_to_last && w_retry_ok) begin
                    w_state_nxt    = S_START;
                    w_retry_nxt    = r_retry + RT_W'(1);
                end else if (w_to_last) begin
                    w_state_nxt    = S_ERR;
                    w_err_code_nxt = ERR_TIMEOUT;
                end
            end
            S_DONE, S_ERR: begin
                w_state_nxt = S_IDLE;
                w_retry_nxt = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Pulses and busy are registered from the next state so they align with it.
    always_ff @(posedge i_Clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_to_cnt   <= '0;
            r_retry    <= '0;
            r_klotski  <= '0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_steps    <= '0;
            r_err_code <= ERR_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_to_cnt   <= w_to_cnt_nxt;
            r_retry    <= w_retry_nxt;
            r_klotski  <= w_klotski_nxt;
            r_start    <= (w_state_nxt == S_START);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= (w_state_nxt == S_DONE);
            r_err      <= (w_state_nxt == S_ERR);
            r_steps    <= w_steps_nxt;
            r_err_code <= w_err_code_nxt;
        end
    end

    assign o_klotski   = r_klotski;
    assign o_start_alg = r_start;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_steps     = r_steps;
    assign o_err       = r_err;
    assign o_err_code  = r_err_code;

endmodule

// File: tb/tb_klotski_solve_ctrl.sv
// Directed bench for klotski_solve_ctrl with a result scoreboard and start-pulse log.
module tb_klotski_solve_ctrl;

    typedef struct packed {
        logic [1:0] kind;   // {done, err}
        logic [7:0] steps;
        logic [1:0] code;
    } exp_t;

    logic                 i_Clk = 1'b0;
    logic                 i_rst_n;
    logic                 i_en;
    logic [3:0][3:0][3:0] i_klotski;
    logic                 i_abort;
    logic                 i_alg_done;
    logic [7:0]           i_alg_steps;
    logic [3:0][3:0][3:0] o_klotski;
    logic                 o_start_alg;
    logic                 o_busy;
    logic                 o_done;
    logic [7:0]           o_steps;
    logic                 o_err;
    logic [1:0]           o_err_code;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_start = 0;
    int   cyc     = 0;
    int   start_cyc[$];
    exp_t exp_q[$];

    localparam logic [63:0] BOARD_GOOD = 64'h0FED_CBA9_8765_4321;
    localparam logic [63:0] BOARD_TWO0 = 64'h00ED_CBA9_8765_4321;
    localparam logic [63:0] BOARD_ALT  = 64'h1234_5678_9ABC_DEF0;

    klotski_solve_ctrl #(
        .ROWS(4), .COLS(4), .CELL_W(4), .STEP_W(8), .TIMEOUT(8), .MAX_RETRY(2)
    ) dut (
        .i_Clk       (i_Clk),
        .i_rst_n     (i_rst_n),
        .i_en        (i_en),
        .i_klotski   (i_klotski),
        .i_abort     (i_abort),
        .i_alg_done  (i_alg_done),
        .i_alg_steps (i_alg_steps),
        .o_klotski   (o_klotski),
        .o_start_alg (o_start_alg),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_steps     (o_steps),
        .o_err       (o_err),
        .o_err_code  (o_err_code)
    );

    always #5 i_Clk = ~i_Clk;

    always @(posedge i_Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    // Result monitor: every done/err pulse must match the oldest queued expectation.
    always @(negedge i_Clk) begin
        exp_t e;
        if (o_start_alg) begin
            n_start++;
            start_cyc.push_back(cyc);
        end
        if (o_done || o_err) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pulse", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                chk("sb_kind", 64'({o_done, o_err}), 64'(e.kind));
                chk("sb_code", 64'(o_err_code), 64'(e.code));
                if (e.kind == 2'b10) chk("sb_steps", 64'(o_steps), 64'(e.steps));
            end
        end
    end

    initial begin
        int s0;
        int n0;
        exp_t e;

        i_rst_n     = 1'b0;
        i_en        = 1'b0;
        i_klotski   = '0;
        i_abort     = 1'b0;
        i_alg_done  = 1'b0;
        i_alg_steps = '0;
        steps(2);

        // Reset state
        chk("rst_busy",  64'(o_busy), 64'd0);
        chk("rst_start", 64'(o_start_alg), 64'd0);
        chk("rst_done",  64'(o_done), 64'd0);
        chk("rst_err",   64'(o_err), 64'd0);
        chk("rst_code",  64'(o_err_code), 64'd0);
        chk("rst_steps", 64'(o_steps), 64'd0);
        chk("rst_board", 64'(o_klotski), 64'd0);
        i_rst_n = 1'b1;
        step();

        // 1: nominal solve, done five cycles after the start pulse
        n0 = n_start;
        i_klotski = BOARD_GOOD;
        i_en = 1'b1;
        step();                                   // N+1 CHECK
        i_en = 1'b0;
        i_klotski = BOARD_ALT;
        chk("t1_busy_n1",  64'(o_busy), 64'd1);
        chk("t1_board_n1", 64'(o_klotski), BOARD_GOOD);
        chk("t1_start_n1", 64'(o_start_alg), 64'd0);
        step();                                   // N+2 START
        chk("t1_start_n2", 64'(o_start_alg), 64'd1);
        step();                                   // N+3 WAIT
        chk("t1_start_n3", 64'(o_start_alg), 64'd0);
        steps(4);                                 // N+7
        i_alg_done = 1'b1;
        i_alg_steps = 8'd37;
        e = '{kind: 2'b10, steps: 8'd37, code: 2'd0};
        exp_q.push_back(e);
        step();                                   // N+8 DONE
        i_alg_done = 1'b0;
        chk("t1_done",  64'(o_done), 64'd1);
        chk("t1_steps", 64'(o_steps), 64'd37);
        chk("t1_code",  64'(o_err_code), 64'd0);
        chk("t1_board_stable", 64'(o_klotski), BOARD_GOOD);
        step();
        chk("t1_done_1cyc", 64'(o_done), 64'd0);
        chk("t1_idle_busy", 64'(o_busy), 64'd0);
        chk("t1_nstart", 64'(n_start - n0), 64'd1);

        // 2: board with two blanks
        n0 = n_start;
        i_klotski = BOARD_TWO0;
        i_en = 1'b1;
        step();
        i_en = 1'b0;
`ifdef KLOTSKI_BLANK_CHECK_EN
        e = '{kind: 2'b01, steps: 8'd0, code: 2'd1};
        exp_q.push_back(e);
        step();                                   // N+2 ERR
        chk("t2_err",   64'(o_err), 64'd1);
        chk("t2_code",  64'(o_err_code), 64'd1);
        chk("t2_start", 64'(o_start_alg), 64'd0);
        step();
        chk("t2_nstart", 64'(n_start - n0), 64'd0);
`else
        step();                                   // N+2 START
        chk("t2_start", 64'(o_start_alg), 64'd1);
        step();
        i_abort = 1'b1;
        e = '{kind: 2'b01, steps: 8'd0, code: 2'd3};
        exp_q.push_back(e);
        step();
        i_abort = 1'b0;
        chk("t2_err",  64'(o_err), 64'd1);
        chk("t2_code", 64'(o_err_code), 64'd3);
        step();
        chk("t2_nstart", 64'(n_start - n0), 64'd1);
`endif
        step();

        // 3: no done at all, two retries then timeout error
        s0 = start_cyc.size();
        i_klotski = BOARD_GOOD;
        i_en = 1'b1;
        step();
        i_en = 1'b0;
        steps(27);                                // N+28, final WAIT cycle
        chk("t3_no_err_yet", 64'(o_err), 64'd0);
        e = '{kind: 2'b01, steps: 8'd0, code: 2'd2};
        exp_q.push_back(e);
        step();                                   // N+29 ERR
        chk("t3_err",  64'(o_err), 64'd1);
        chk("t3_code", 64'(o_err_code), 64'd2);
        chk("t3_nstart", 64'(start_cyc.size() - s0), 64'd3);
        if (start_cyc.size() - s0 == 3) begin
            chk("t3_gap1", 64'(start_cyc[s0+1] - start_cyc[s0]), 64'd9);
            chk("t3_gap2", 64'(start_cyc[s0+2] - start_cyc[s0+1]), 64'd9);
        end
        step();
        chk("t3_code_hold", 64'(o_err_code), 64'd2);
        chk("t3_idle", 64'(o_busy), 64'd0);
        step();

        // 4a: done on the final timeout count wins over a retry
        n0 = n_start;
        i_en = 1'b1;
        step();
        i_en = 1'b0;
        chk("t4_code_clr", 64'(o_err_code), 64'd0);
        steps(9);                                 // N+10, counter = 7
        i_alg_done = 1'b1;
        i_alg_steps = 8'd99;
        e = '{kind: 2'b10, steps: 8'd99, code: 2'd0};
        exp_q.push_back(e);
        step();
        i_alg_done = 1'b0;
        chk("t4_done",  64'(o_done), 64'd1);
        chk("t4_noretry", 64'(o_start_alg), 64'd0);
        step();
        chk("t4_nstart", 64'(n_start - n0), 64'd1);

        // 4b: done during START is ignored
        i_en = 1'b1;
        step();
        i_en = 1'b0;
        step();                                   // START
        i_alg_done = 1'b1;
        i_alg_steps = 8'd5;
        step();                                   // WAIT
        i_alg_done = 1'b0;
        chk("t4b_no_done", 64'(o_done), 64'd0);
        chk("t4b_busy", 64'(o_busy), 64'd1);
        i_alg_done = 1'b1;
        i_alg_steps = 8'd12;
        e = '{kind: 2'b10, steps: 8'd12, code: 2'd0};
        exp_q.push_back(e);
        step();
        i_alg_done = 1'b0;
        chk("t4b_done", 64'(o_done), 64'd1);
        chk("t4b_steps", 64'(o_steps), 64'd12);
        steps(2);

        // 5: abort with done on the third WAIT cycle; i_en while busy ignored
        i_klotski = BOARD_GOOD;
        i_en = 1'b1;
        step();
        i_en = 1'b0;
        steps(2);                                 // N+3 WAIT1
        i_klotski = BOARD_ALT;
        i_en = 1'b1;
        step();
        i_en = 1'b0;
        step();                                   // N+5 WAIT3
        i_abort = 1'b1;
        i_alg_done = 1'b1;
        i_alg_steps = 8'd50;
        e = '{kind: 2'b01, steps: 8'd0, code: 2'd3};
        exp_q.push_back(e);
        step();                                   // N+6 ERR
        i_abort = 1'b0;
        i_en = 1'b1;                              // same cycle as the err pulse
        chk("t5_err",  64'(o_err), 64'd1);
        chk("t5_done", 64'(o_done), 64'd0);
        chk("t5_code", 64'(o_err_code), 64'd3);
        step();
        i_en = 1'b0;
        i_alg_done = 1'b0;
        chk("t5_idle", 64'(o_busy), 64'd0);
        chk("t5_board_kept", 64'(o_klotski), BOARD_GOOD);
        step();
        chk("t5_en_ignored", 64'(o_busy), 64'd0);

        // 6: reset mid-WAIT, then a normal run
        i_klotski = BOARD_GOOD;
        i_en = 1'b1;
        step();
        i_en = 1'b0;
        steps(3);                                 // WAIT, counter = 1
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
        chk("t6_busy",  64'(o_busy), 64'd0);
        chk("t6_start", 64'(o_start_alg), 64'd0);
        chk("t6_done",  64'(o_done), 64'd0);
        chk("t6_err",   64'(o_err), 64'd0);
        chk("t6_board", 64'(o_klotski), 64'd0);
        n0 = n_start;
        steps(12);
        chk("t6_quiet", 64'(n_start - n0), 64'd0);
        i_en = 1'b1;
        step();
        i_en = 1'b0;
        steps(3);
        i_alg_done = 1'b1;
        i_alg_steps = 8'd7;
        e = '{kind: 2'b10, steps: 8'd7, code: 2'd0};
        exp_q.push_back(e);
        step();
        i_alg_done = 1'b0;
        chk("t6_run_done", 64'(o_done), 64'd1);
        chk("t6_run_steps", 64'(o_steps), 64'd7);
        steps(3);

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
